// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 serial receive front-end for the AHB UART.
// Synchronises serialRx, times bits with a 16x oversample tick, takes a
// 3-sample majority vote at mid-bit and hands each good byte to the RX FIFO
// as a one-cycle strobe. Framing errors and overruns are single-cycle pulses.
module uart_rx_core #(
  parameter int unsigned BAUD_DIV = 27
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       serialRx,
  input  logic       rxFull,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       frameErr,
  output logic       overrun,
  output logic       rxBusy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] STOP     = 3'd3;
  localparam logic [2:0] WAITHIGH = 3'd4;

  localparam logic [15:0] TICK_LAST = 16'(BAUD_DIV - 1);

  logic [2:0]  state;
  logic        sync_meta;
  logic        rxs;
  logic [15:0] baud_cnt;
  logic        tick;
  logic [3:0]  ph;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        samp6;
  logic        samp7;
  logic        vote;
  logic        vote_tick;
  logic        wrap_tick;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_meta <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      sync_meta <= serialRx;
      rxs       <= sync_meta;
    end
  end

  // Oversample divider, held at zero in IDLE so bit timing starts at the edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      baud_cnt <= '0;
    end else if ((state == IDLE) || (baud_cnt == TICK_LAST)) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

  assign tick      = (state != IDLE) && (baud_cnt == TICK_LAST);
  assign vote_tick = tick && (ph == 4'd8);
  assign wrap_tick = tick && (ph == 4'd15);

  // Phase within the current bit, sixteen ticks per bit, wrapping at 15.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ph <= '0;
    end else if (state == IDLE) begin
      ph <= '0;
    end else if (tick) begin
      ph <= ph + 4'd1;
    end
  end

  // Capture the two early mid-bit samples; the third is rxs itself at ph 8.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      samp6 <= 1'b1;
      samp7 <= 1'b1;
    end else if (tick) begin
      if (ph == 4'd6) samp6 <= rxs;
      if (ph == 4'd7) samp7 <= rxs;
    end
  end

  // Two-of-three majority so a single noisy sample cannot flip a bit.
  always_comb begin
    vote = (samp6 & samp7) | (samp6 & rxs) | (samp7 & rxs);
  end

  // Frame state machine, shift register and registered result pulses.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      rxData   <= '0;
      rxValid  <= 1'b0;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      rxValid  <= 1'b0;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (vote_tick && vote) begin
            state <= IDLE;
          end else if (wrap_tick) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (vote_tick) begin
            shreg <= {vote, shreg[7:1]};
          end
          if (wrap_tick) begin
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        STOP: begin
          if (vote_tick) begin
            if (vote) begin
              if (rxFull) begin
                overrun <= 1'b1;
              end else begin
                rxData  <= shreg;
                rxValid <= 1'b1;
              end
              state <= IDLE;
            end else begin
              frameErr <= 1'b1;
              state    <= WAITHIGH;
            end
          end
        end
        WAITHIGH: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign rxBusy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench for uart_rx_core.
// Each scenario pushes the events it expects (kind + rxData) before driving
// the line; a negedge monitor pops and compares whenever a result pulse fires.
module tb_uart_rx_core;

  localparam int BD      = 4;
  localparam int BIT_CYC = 16 * BD;

  localparam logic [1:0] K_VALID = 2'd1;
  localparam logic [1:0] K_OVR   = 2'd2;
  localparam logic [1:0] K_FERR  = 2'd3;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       serialRx = 1'b1;
  logic       rxFull = 1'b0;
  logic [7:0] rxData;
  logic       rxValid;
  logic       frameErr;
  logic       overrun;
  logic       rxBusy;

  ev_t        exp_q[$];
  ev_t        mon_e;
  logic [1:0] mon_kind;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx_core #(.BAUD_DIV(BD)) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .serialRx(serialRx),
    .rxFull(rxFull),
    .rxData(rxData),
    .rxValid(rxValid),
    .frameErr(frameErr),
    .overrun(overrun),
    .rxBusy(rxBusy)
  );

  always #5 HCLK = ~HCLK;

  // Scoreboard monitor: every result pulse must be exclusive and match the queue head.
  always @(negedge HCLK) begin
    if (HRESETn && (rxValid || frameErr || overrun)) begin
      n_checks++;
      if ((int'(rxValid) + int'(frameErr) + int'(overrun)) > 1) begin
        $display("[TB] FAIL exclusive: rxValid=%0b overrun=%0b frameErr=%0b, required at most one high",
                 rxValid, overrun, frameErr);
      end else begin
        n_pass++;
      end
      mon_kind = rxValid ? K_VALID : (overrun ? K_OVR : K_FERR);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_event: kind=%0d rxData=%02h, required no event", mon_kind, rxData);
      end else begin
        mon_e = exp_q.pop_front();
        if ((mon_kind !== mon_e.kind) || (rxData !== mon_e.data)) begin
          $display("[TB] FAIL event: kind=%0d rxData=%02h, required kind=%0d rxData=%02h",
                   mon_kind, rxData, mon_e.kind, mon_e.data);
        end else begin
          n_pass++;
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic v);
    serialRx = v;
    repeat (BIT_CYC) @(negedge HCLK);
  endtask

  // Send one 8N1 frame; spike_bit >= 0 puts a one-tick low spike mid-bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int spike_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if ((i == spike_bit) && b[i]) begin
        serialRx = 1'b1;
        repeat (7 * BD) @(negedge HCLK);
        serialRx = 1'b0;
        repeat (BD) @(negedge HCLK);
        serialRx = 1'b1;
        repeat (8 * BD) @(negedge HCLK);
      end else begin
        drive_bit(b[i]);
      end
    end
    drive_bit(stop_val);
  endtask

  task automatic wait_drain(input int max_cyc, output bit ok);
    for (int i = 0; (i < max_cyc) && (exp_q.size() != 0); i++) @(negedge HCLK);
    ok = (exp_q.size() == 0);
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    serialRx = 1'b1;
    repeat (5) @(negedge HCLK);
    n_checks++;
    if (rxData !== 8'h00) $display("[TB] FAIL reset_rxData: got %02h required 00", rxData);
    else n_pass++;
    n_checks++;
    if ({rxValid, frameErr, overrun} !== 3'b000)
      $display("[TB] FAIL reset_pulses: got %03b required 000", {rxValid, frameErr, overrun});
    else n_pass++;
    n_checks++;
    if (rxBusy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b required 0", rxBusy);
    else n_pass++;
    HRESETn = 1'b1;
    repeat (BIT_CYC) @(negedge HCLK);
    n_checks++;
    if (rxBusy !== 1'b0) $display("[TB] FAIL idle_busy: got %0b required 0", rxBusy);
    else n_pass++;
  endtask

  task automatic test_basic();
    bit ok;
    push_exp(K_VALID, 8'h78);
    send_frame(8'h78, 1'b1, -1);
    wait_drain(BIT_CYC, ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL basic_timeout: %0d events pending, required 0", exp_q.size());
    else n_pass++;
    last_good = 8'h78;
    repeat (BIT_CYC) @(negedge HCLK);
    n_checks++;
    if (rxBusy !== 1'b0) $display("[TB] FAIL basic_busy: got %0b required 0", rxBusy);
    else n_pass++;
    n_checks++;
    if (rxData !== 8'h78) $display("[TB] FAIL basic_hold: got %02h required 78", rxData);
    else n_pass++;
  endtask

  task automatic test_glitch();
    bit ok;
    serialRx = 1'b0;
    repeat (2 * BD) @(negedge HCLK);
    n_checks++;
    if (rxBusy !== 1'b1) $display("[TB] FAIL glitch_start_busy: got %0b required 1", rxBusy);
    else n_pass++;
    repeat (2 * BD) @(negedge HCLK);
    serialRx = 1'b1;
    repeat (2 * BIT_CYC) @(negedge HCLK);
    n_checks++;
    if (rxBusy !== 1'b0) $display("[TB] FAIL glitch_busy: got %0b required 0", rxBusy);
    else n_pass++;
    n_checks++;
    if (rxData !== last_good) $display("[TB] FAIL glitch_hold: got %02h required %02h", rxData, last_good);
    else n_pass++;
    push_exp(K_VALID, 8'h56);
    send_frame(8'h56, 1'b1, -1);
    wait_drain(BIT_CYC, ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL glitch_timeout: %0d events pending, required 0", exp_q.size());
    else n_pass++;
    last_good = 8'h56;
    repeat (BIT_CYC) @(negedge HCLK);
  endtask

  task automatic test_frame_error();
    bit ok;
    push_exp(K_FERR, last_good);
    send_frame(8'h55, 1'b0, -1);
    serialRx = 1'b0;
    repeat (BIT_CYC + BIT_CYC / 2) @(negedge HCLK);
    n_checks++;
    if (rxBusy !== 1'b1) $display("[TB] FAIL break_busy: got %0b required 1", rxBusy);
    else n_pass++;
    repeat (BIT_CYC + BIT_CYC / 2) @(negedge HCLK);
    serialRx = 1'b1;
    repeat (BIT_CYC) @(negedge HCLK);
    wait_drain(BIT_CYC, ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL ferr_timeout: %0d events pending, required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (rxBusy !== 1'b0) $display("[TB] FAIL ferr_busy: got %0b required 0", rxBusy);
    else n_pass++;
    push_exp(K_VALID, 8'h34);
    send_frame(8'h34, 1'b1, -1);
    wait_drain(BIT_CYC, ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL ferr_next_timeout: %0d events pending, required 0", exp_q.size());
    else n_pass++;
    last_good = 8'h34;
    repeat (BIT_CYC) @(negedge HCLK);
  endtask

  task automatic test_overrun();
    bit ok;
    rxFull = 1'b1;
    push_exp(K_OVR, last_good);
    send_frame(8'h12, 1'b1, -1);
    wait_drain(BIT_CYC, ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL ovr_timeout: %0d events pending, required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (rxData !== last_good) $display("[TB] FAIL ovr_hold: got %02h required %02h", rxData, last_good);
    else n_pass++;
    rxFull = 1'b0;
    repeat (BIT_CYC) @(negedge HCLK);
    push_exp(K_VALID, 8'h9A);
    send_frame(8'h9A, 1'b1, -1);
    wait_drain(BIT_CYC, ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL ovr_next_timeout: %0d events pending, required 0", exp_q.size());
    else n_pass++;
    last_good = 8'h9A;
    repeat (BIT_CYC) @(negedge HCLK);
  endtask

  task automatic test_spike();
    bit ok;
    push_exp(K_VALID, 8'hFF);
    send_frame(8'hFF, 1'b1, 3);
    wait_drain(BIT_CYC, ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL spike_timeout: %0d events pending, required 0", exp_q.size());
    else n_pass++;
    last_good = 8'hFF;
    repeat (BIT_CYC) @(negedge HCLK);
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int b = 20; b < 40; b++) begin
      push_exp(K_VALID, 8'(b));
      send_frame(8'(b), 1'b1, -1);
    end
    n_checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL b2b_pending: %0d events pending, required 0", exp_q.size());
    else n_pass++;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    serialRx = 1'b0;
    repeat (BIT_CYC / 2) @(negedge HCLK);
    HRESETn = 1'b0;
    serialRx = 1'b1;
    repeat (4) @(negedge HCLK);
    n_checks++;
    if ({rxValid, frameErr, overrun, rxBusy} !== 4'b0000)
      $display("[TB] FAIL midreset_outputs: got %04b required 0000", {rxValid, frameErr, overrun, rxBusy});
    else n_pass++;
    n_checks++;
    if (rxData !== 8'h00) $display("[TB] FAIL midreset_rxData: got %02h required 00", rxData);
    else n_pass++;
    last_good = 8'h00;
    HRESETn = 1'b1;
    repeat (BIT_CYC) @(negedge HCLK);
    push_exp(K_VALID, 8'd41);
    send_frame(8'd41, 1'b1, -1);
    wait_drain(BIT_CYC, ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL after_reset_timeout: %0d events pending, required 0", exp_q.size());
    else n_pass++;
    last_good = 8'd41;
    repeat (BIT_CYC) @(negedge HCLK);
    n_checks++;
    if (rxData !== 8'd41) $display("[TB] FAIL after_reset_hold: got %02h required 29", rxData);
    else n_pass++;
  endtask

  initial begin
    @(negedge HCLK);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_spike();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive front-end of the AHB UART: synchronises the asynchronous `serialRx` line, recovers 8N1 frames using 16x oversampling with majority voting, and delivers each received byte as a one-cycle write strobe into the UART's RX FIFO. It sits directly upstream of the RX FIFO / AHB register block, which supplies `rxFull` and captures `rxData` on `rxValid`. Framing errors and overruns are reported as single-cycle pulses for the status and interrupt logic.

## Interface

- `BAUD_DIV`, 27, HCLK cycles per oversample tick (1/16 bit). 27 gives ~115200 baud at 50 MHz. Legal range 2..65535.
- `HCLK  in  1  bus clock; all logic on rising edge`
- `HRESETn  in  1  reset, asynchronous, active-low`
- `serialRx  in  1  asynchronous serial input, idle high, 8N1, LSB first`
- `rxFull  in  1  RX FIFO full; sampled in the stop-bit decision cycle`
- `rxData  out  8  last accepted byte; updates only when rxValid asserts`
- `rxValid  out  1  one-cycle strobe: rxData holds a new byte, FIFO must push`
- `frameErr  out  1  one-cycle pulse: stop bit sampled low`
- `overrun  out  1  one-cycle pulse: good frame received while rxFull=1, byte dropped`
- `rxBusy  out  1  high in every state except IDLE`

## Operation

- Synchroniser: two flops on `serialRx`, both reset to 1; output `rxs` is the only internal view of the line.
- Tick generator: counter 0..BAUD_DIV-1; `tick` asserts in the cycle the counter equals BAUD_DIV-1, then wraps to 0. Counter is cleared to 0 on entry to START so bit timing aligns to the detected edge.
- Phase counter `ph` (4 bits) advances on each tick, wraps 15->0; marks bit boundary. Bit counter (3 bits) counts data bits.
- Majority vote: `rxs` sampled on ticks with ph = 6, 7, 8; bit value = majority of the three, decided on the ph=8 tick.
- States:
  - IDLE: `rxs`=0 -> START (clear tick counter, ph, bit counter).
  - START: voted bit 0 -> continue, DATA at ph wrap; voted 1 -> IDLE (glitch rejected, no outputs).
  - DATA: each voted bit shifts into shift register from MSB side (LSB first on line); after 8th bit, at ph wrap -> STOP.
  - STOP: voted 1 and rxFull=0 -> `rxData` <= shift register, `rxValid` pulse, -> IDLE. Voted 1 and rxFull=1 -> `overrun` pulse, `rxData` unchanged, -> IDLE. Voted 0 -> `frameErr` pulse, -> WAITHIGH.
  - WAITHIGH: stays until `rxs`=1, then IDLE (a break condition produces exactly one frameErr, no repeated frames).
- Return to IDLE happens at mid-stop-bit, so a following start bit one half-bit later is caught (back-to-back frames with one stop bit supported).
- Only one of rxValid / overrun / frameErr may assert in any cycle.

## Timing

- Reset values: rxData=0x00, rxValid=0, frameErr=0, overrun=0, rxBusy=0, state IDLE, synchroniser flops 1, all counters 0. Reset mid-frame aborts immediately; the partial byte is discarded.
- Line falling edge to START entry: 2-3 HCLK (synchroniser).
- START entry to stop-bit decision tick: 153*BAUD_DIV cycles (bit 9, ph 8). rxValid/overrun/frameErr are registered and high in the following cycle, for exactly one cycle.
- rxData is stable from the rxValid cycle until the next rxValid.
- rxBusy rises the cycle after START entry and falls in the same cycle rxValid/overrun/frameErr asserts (or after WAITHIGH exit).
- Glitch rejection: a low pulse shorter than ~6 ticks on the start bit returns to IDLE at the START ph=8 tick with no outputs.

## Test plan

- Bench bit-driver at 16*BAUD_DIV cycles/bit sends 0x78 -> exactly one rxValid, rxData=0x78, frameErr=overrun=0, rxBusy low afterwards.
- Glitch: line low for 4*BAUD_DIV cycles then high -> no rxValid/frameErr, state back to IDLE; subsequent 0x56 received correctly.
- Stop bit driven low on 0x55, line held low 3 bit times, then 0x34 sent -> one frameErr pulse, no rxValid for 0x55, then rxValid with rxData=0x34.
- rxFull=1 during frame 0x12 -> one overrun pulse, no rxValid, rxData keeps previous value; rxFull=0 then 0x9A -> rxValid, rxData=0x9A.
- Single-tick low spike in the middle of a '1' data bit of 0xFF -> majority corrects, rxData=0xFF.
- Back-to-back frames 20..39 with one stop bit, then HRESETn pulsed mid-frame of 40 -> 20 rxValid strobes in order with rxData=20..39; outputs 0 during reset; byte 41 after reset received correctly.
